// File: rtl/csel_pkg.sv
// csel_pkg: default widths and segment/payload types for the carry-select subtractor.
// CSEL_SUB_OVF_EN adds the operand sign bits to the stage-1 payload.
package csel_pkg;
   localparam int CSEL_W    = 25;
   localparam int CSEL_LO_W = 12;
   localparam int CSEL_HI_W = CSEL_W - CSEL_LO_W;
   typedef struct packed {
      logic                 carry;
      logic [CSEL_LO_W-1:0] sum;
   } lo_seg_t;
   typedef struct packed {
      logic                 carry;
      logic [CSEL_HI_W-1:0] sum;
   } hi_seg_t;
   typedef struct packed {
      lo_seg_t lo_sum;
      hi_seg_t hi0;
      hi_seg_t hi1;
`ifdef CSEL_SUB_OVF_EN
      logic    x_sign;
      logic    y_sign;
`endif
   } s1_payload_t;
endpackage

// File: rtl/csel_sum_pair.sv
// csel_sum_pair: one carry-select segment, {carry,sum} of a + b_n for cin=0 and cin=1.
module csel_sum_pair
   import csel_pkg::*;
#(
   parameter int N = CSEL_HI_W
) (
   input  logic [N-1:0] a,
   input  logic [N-1:0] b_n,
   output logic [N:0]   sum0,
   output logic [N:0]   sum1
);
   always_comb begin
      sum0 = {1'b0, a} + {1'b0, b_n};
      sum1 = {1'b0, a} + {1'b0, b_n} + (N+1)'(1);
   end
endmodule

// File: rtl/csel_pipe_subtractor.sv
// csel_pipe_subtractor: two-stage valid/ready pipelined D = X - Y via carry-select X + ~Y + 1.
// Define CSEL_SUB_OVF_EN to add the registered signed-overflow output ovf.
module csel_pipe_subtractor
   import csel_pkg::*;
#(
   parameter int W    = CSEL_W,
   parameter int LO_W = CSEL_LO_W
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [W-1:0] x,
   input  logic [W-1:0] y,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] diff,
   output logic         borrow
`ifdef CSEL_SUB_OVF_EN
   ,
   output logic         ovf
`endif
);
   localparam int HI_W = W - LO_W;
   // Local copies of the package types, sized by this instance's parameters
   typedef struct packed {
      logic            carry;
      logic [LO_W-1:0] sum;
   } lo_t;
   typedef struct packed {
      logic            carry;
      logic [HI_W-1:0] sum;
   } hi_t;
   typedef struct packed {
      lo_t  lo_sum;
      hi_t  hi0;
      hi_t  hi1;
`ifdef CSEL_SUB_OVF_EN
      logic x_sign;
      logic y_sign;
`endif
   } s1_t;
   s1_t          s1_q, s1_d;
   logic         s1_valid_q, s1_valid_d;
   logic         out_valid_q, out_valid_d;
   logic [W-1:0] diff_q, diff_d;
   logic         borrow_q, borrow_d;
   logic         s2_adv, s1_adv, accept;
   hi_t          hi0, hi1, hi_sel;
`ifdef CSEL_SUB_OVF_EN
   logic         ovf_q, ovf_d;
`endif
   csel_sum_pair #(.N(HI_W)) u_hi (
      .a    (x[W-1:LO_W]),
      .b_n  (~y[W-1:LO_W]),
      .sum0 (hi0),
      .sum1 (hi1)
   );
   always_comb begin
      s2_adv      = ~out_valid_q | out_ready;
      s1_adv      = s1_valid_q & s2_adv;
      in_ready    = ~s1_valid_q | s2_adv;
      accept      = in_valid & in_ready;
      s1_d        = s1_q;
      if (accept) begin
         s1_d.lo_sum = {1'b0, x[LO_W-1:0]} + {1'b0, ~y[LO_W-1:0]} + (LO_W+1)'(1);
         s1_d.hi0    = hi0;
         s1_d.hi1    = hi1;
`ifdef CSEL_SUB_OVF_EN
         s1_d.x_sign = x[W-1];
         s1_d.y_sign = y[W-1];
`endif
      end
      s1_valid_d  = accept | (s1_valid_q & ~s2_adv);
      out_valid_d = s2_adv ? s1_valid_q : out_valid_q;
      hi_sel      = s1_q.lo_sum.carry ? s1_q.hi1 : s1_q.hi0;
      diff_d      = s1_adv ? {hi_sel.sum, s1_q.lo_sum.sum} : diff_q;
      borrow_d    = s1_adv ? ~hi_sel.carry : borrow_q;
`ifdef CSEL_SUB_OVF_EN
      ovf_d       = s1_adv ? (s1_q.x_sign ^ s1_q.y_sign) & (hi_sel.sum[HI_W-1] ^ s1_q.x_sign) : ovf_q;
`endif
   end
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         s1_q        <= '0;
         s1_valid_q  <= 1'b0;
         out_valid_q <= 1'b0;
         diff_q      <= '0;
         borrow_q    <= 1'b0;
`ifdef CSEL_SUB_OVF_EN
         ovf_q       <= 1'b0;
`endif
      end else begin
         s1_q        <= s1_d;
         s1_valid_q  <= s1_valid_d;
         out_valid_q <= out_valid_d;
         diff_q      <= diff_d;
         borrow_q    <= borrow_d;
`ifdef CSEL_SUB_OVF_EN
         ovf_q       <= ovf_d;
`endif
      end
   end
   assign out_valid = out_valid_q;
   assign diff      = diff_q;
   assign borrow    = borrow_q;
`ifdef CSEL_SUB_OVF_EN
   assign ovf       = ovf_q;
`endif
endmodule

// File: tb/tb_csel_pipe_subtractor.sv
// tb_csel_pipe_subtractor: directed-vector bench for csel_pipe_subtractor (W=25, LO_W=12).
module tb_csel_pipe_subtractor;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [24:0] x = '0;
   logic [24:0] y = '0;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic [24:0] diff;
   logic        borrow;
`ifdef CSEL_SUB_OVF_EN
   logic        ovf;
`endif
   int          n_chk = 0;
   int          n_fail = 0;
   csel_pipe_subtractor dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .x         (x),
      .y         (y),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .diff      (diff),
`ifdef CSEL_SUB_OVF_EN
      .ovf       (ovf),
`endif
      .borrow    (borrow)
   );
   always #5 clk = ~clk;
   initial begin
      #400000;
      $display("FAIL watchdog act=timeout exp=finish");
      $fatal(1, "watchdog");
   end
   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s act=%h exp=%h", tag, act, exp);
      end
   endtask
   task automatic step();
      @(posedge clk);
      #1;
   endtask
   // Single transaction with out_ready high: checks 2-cycle latency and result.
   task automatic run_one(input string tag, input logic [24:0] xv, input logic [24:0] yv,
                          input logic [24:0] ed, input logic eb, input logic eo);
      x = xv;
      y = yv;
      in_valid = 1'b1;
      chk({tag, "_rdy"}, 32'(in_ready), 32'd1);
      step();
      in_valid = 1'b0;
      chk({tag, "_lat1"}, 32'(out_valid), 32'd0);
      step();
      chk({tag, "_vld"}, 32'(out_valid), 32'd1);
      chk({tag, "_diff"}, 32'(diff), 32'(ed));
      chk({tag, "_brw"}, 32'(borrow), 32'(eb));
`ifdef CSEL_SUB_OVF_EN
      chk({tag, "_ovf"}, 32'(ovf), 32'(eo));
`else
      if (eo !== 1'bx) begin end
`endif
      step();
   endtask
   logic [24:0] bx[8] = '{25'h0000010, 25'h1000000, 25'h0000001, 25'h0123000,
                          25'h1FFFFFF, 25'h0000000, 25'h0ABC000, 25'h0000FFF};
   logic [24:0] by[8] = '{25'h0000001, 25'h0000001, 25'h0000002, 25'h0023000,
                          25'h1FFFFFF, 25'h1000000, 25'h0000ABC, 25'h0001001};
   logic [24:0] bd[8] = '{25'h000000F, 25'h0FFFFFF, 25'h1FFFFFF, 25'h0100000,
                          25'h0000000, 25'h1000000, 25'h0ABB544, 25'h1FFFFFE};
   logic        bb[8] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
   initial begin
      int k;
      int stall;
      bit stalled;
      bit saw_full;
      repeat (2) step();
      chk("rst_vld", 32'(out_valid), 32'd0);
      chk("rst_diff", 32'(diff), 32'd0);
      chk("rst_brw", 32'(borrow), 32'd0);
      rst_n = 1'b1;
      chk("rst_rel_rdy", 32'(in_ready), 32'd1);
      run_one("t1", 25'h1ABCDEF, 25'h0123456, 25'h1999999, 1'b0, 1'b0);
      run_one("wrap", 25'h0000000, 25'h0000001, 25'h1FFFFFF, 1'b1, 1'b0);
      run_one("eq", 25'h155AAAA, 25'h155AAAA, 25'h0000000, 1'b0, 1'b0);
      run_one("lo_cy_a", 25'h0001000, 25'h0000FFF, 25'h0000001, 1'b0, 1'b0);
      run_one("lo_cy_b", 25'h0000FFF, 25'h0001000, 25'h1FFFFFF, 1'b1, 1'b0);
`ifdef CSEL_SUB_OVF_EN
      run_one("ovf1", 25'h0FFFFFF, 25'h1FFFFFF, 25'h1000000, 1'b1, 1'b1);
      run_one("ovf0", 25'h0000003, 25'h0000001, 25'h0000002, 1'b0, 1'b0);
`endif
      // Streaming with a 3-cycle consumer stall after the third result
      k = 0;
      stall = 0;
      stalled = 1'b0;
      saw_full = 1'b0;
      fork
         begin
            for (int i = 0; i < 8; i++) begin
               bit rdy;
               int tries;
               x = bx[i];
               y = by[i];
               in_valid = 1'b1;
               tries = 0;
               do begin
                  @(negedge clk);
                  rdy = in_ready;
                  @(posedge clk);
                  #1;
                  tries++;
               end while (!rdy && tries < 20);
               if (!rdy) chk("bp_drv_timeout", 32'(rdy), 32'd1);
            end
            in_valid = 1'b0;
         end
         begin
            for (int c = 0; c < 60 && k < 8; c++) begin
               @(negedge clk);
               if (stall > 0) begin
                  chk("bp_stall_vld", 32'(out_valid), 32'd1);
                  chk("bp_stall_diff", 32'(diff), 32'(bd[k]));
                  chk("bp_stall_brw", 32'(borrow), 32'(bb[k]));
                  if (!in_ready) saw_full = 1'b1;
               end else if (out_valid) begin
                  chk($sformatf("bp_diff%0d", k), 32'(diff), 32'(bd[k]));
                  chk($sformatf("bp_brw%0d", k), 32'(borrow), 32'(bb[k]));
                  k++;
               end
               @(posedge clk);
               #1;
               if (stall > 0) stall--;
               if (k == 3 && !stalled) begin
                  stall = 3;
                  stalled = 1'b1;
               end
               out_ready = (stall == 0);
            end
            out_ready = 1'b1;
         end
      join
      chk("bp_count", 32'(k), 32'd8);
      chk("bp_in_ready_drop", 32'(saw_full), 32'd1);
      step();
      chk("bp_empty", 32'(out_valid), 32'd0);
      // Reset with both stages valid
      out_ready = 1'b0;
      x = 25'h0000005;
      y = 25'h0000002;
      in_valid = 1'b1;
      step();
      x = 25'h0000009;
      step();
      in_valid = 1'b0;
      chk("mr_full_vld", 32'(out_valid), 32'd1);
      chk("mr_full_rdy", 32'(in_ready), 32'd0);
      rst_n = 1'b0;
      step();
      chk("mr_vld", 32'(out_valid), 32'd0);
      chk("mr_diff", 32'(diff), 32'd0);
      chk("mr_brw", 32'(borrow), 32'd0);
      rst_n = 1'b1;
      out_ready = 1'b1;
      chk("mr_rel_rdy", 32'(in_ready), 32'd1);
      for (int c = 0; c < 4; c++) begin
         step();
         chk($sformatf("mr_stale%0d", c), 32'(out_valid), 32'd0);
      end
      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end
endmodule
